// File: rtl/dmem_pkg.sv
// Shared encodings and FSM state type for the RV32 data memory controller.
// DMEM_MISALIGN_SPLIT_EN adds the BEAT2 state used for two-beat misaligned accesses.
package dmem_pkg;

  localparam int NLANES = 4;

  localparam logic [2:0] CTL_BU = 3'b000;
  localparam logic [2:0] CTL_HU = 3'b001;
  localparam logic [2:0] CTL_W  = 3'b010;
  localparam logic [2:0] CTL_B  = 3'b100;
  localparam logic [2:0] CTL_H  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_RESP  = 2'd2
`ifdef DMEM_MISALIGN_SPLIT_EN
    ,
    ST_BEAT2 = 2'd3
`endif
  } dmem_state_e;

  function automatic logic ctl_illegal(input logic [2:0] ctl);
    return !(ctl inside {CTL_BU, CTL_HU, CTL_W, CTL_B, CTL_H});
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// One byte lane of data storage: DEPTH_WORDS x 8 synchronous RAM with registered read.
// Read returns the pre-write contents when read and write hit the same entry.
module dmem_bank #(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH_WORDS];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// RV32 byte-addressable data memory with valid/ready request and response ports.
// Define DMEM_MISALIGN_SPLIT_EN to split misaligned in-range accesses into two beats.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_ctl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) << 2;

  dmem_state_e r_state;
  logic              r_we;
  logic [2:0]        r_ctl;
  logic [1:0]        r_off;
  logic [AW-1:0]     r_widx;
  logic              r_err;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
  logic              r_split;
  logic [NLANES-1:0] r_mask2;
  logic [31:0]       r_wrot;
  logic [31:0]       r_b1;
`endif

  logic              w_accept;
  logic [2:0]        w_nbytes;
  logic [7:0]        w_base;
  logic [7:0]        w_mask8;
  logic [32:0]       w_last;
  logic              w_misal;
  logic              w_err;
  logic [5:0]        w_wsh;
  logic [31:0]       w_rot;
  logic [5:0]        w_rsh;
  logic [31:0]       w_lo;
  logic [31:0]       w_hi;
  logic [31:0]       w_ld;
  logic [31:0]       w_rd;
  logic [NLANES-1:0] w_bank_we;
  logic [AW-1:0]     w_bank_addr;
  logic [31:0]       w_bank_wdata;

  function automatic logic [31:0] extend(input logic [2:0] ctl, input logic [31:0] d);
    case (ctl[1:0])
      2'b00:   return {{24{ctl[2] & d[7]}}, d[7:0]};
      2'b01:   return {{16{ctl[2] & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    case (req_ctl[1:0])
      2'b00:   begin w_nbytes = 3'd1; w_base = 8'h01; end
      2'b01:   begin w_nbytes = 3'd2; w_base = 8'h03; end
      default: begin w_nbytes = 3'd4; w_base = 8'h0F; end
    endcase
  end

  // Lane mask over two consecutive words; the upper nibble is the second-beat lanes.
  assign w_mask8 = w_base << req_addr[1:0];
  assign w_last  = {1'b0, req_addr} + {30'd0, w_nbytes} - 33'd1;
  assign w_misal = ((req_ctl[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_ctl[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`ifdef DMEM_MISALIGN_SPLIT_EN
  assign w_err   = ctl_illegal(req_ctl) || (w_last >= MEM_BYTES);
`else
  assign w_err   = ctl_illegal(req_ctl) || (w_last >= MEM_BYTES) || w_misal;
`endif

  // Rotating store data by the byte offset places data byte i on lane (offset+i) mod 4.
  assign w_wsh = {1'b0, req_addr[1:0], 3'b000};
  assign w_rot = (req_wdata << w_wsh) | (req_wdata >> (6'd32 - w_wsh));

  always_comb begin
    w_bank_addr  = req_addr[AW+1:2];
    w_bank_wdata = w_rot;
    w_bank_we    = '0;
    if (r_state == ST_IDLE) begin
      if (w_accept && req_we && !w_err && rst_n) w_bank_we = w_mask8[3:0];
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    else if (r_state == ST_ACC && r_split) begin
      w_bank_addr  = r_widx + 1'b1;
      w_bank_wdata = r_wrot;
      if (r_we && rst_n) w_bank_we = r_mask2;
    end
`endif
  end

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
      .clk     (clk),
      .i_we    (w_bank_we[g]),
      .i_addr  (w_bank_addr),
      .i_wdata (w_bank_wdata[8*g +: 8]),
      .o_rdata (w_rd[8*g +: 8])
    );
  end

  always_comb begin
    w_lo = w_rd;
    w_hi = '0;
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (r_state == ST_BEAT2) begin
      w_lo = r_b1;
      w_hi = w_rd;
    end
`endif
  end

  assign w_rsh = {1'b0, r_off, 3'b000};
  assign w_ld  = (w_lo >> w_rsh) | (w_hi << (6'd32 - w_rsh));

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we   <= req_we;
      r_ctl  <= req_ctl;
      r_off  <= req_addr[1:0];
      r_widx <= req_addr[AW+1:2];
      r_err  <= w_err;
`ifdef DMEM_MISALIGN_SPLIT_EN
      r_split <= w_misal && !w_err;
      r_mask2 <= w_mask8[7:4];
      r_wrot  <= w_rot;
`endif
    end
`ifdef DMEM_MISALIGN_SPLIT_EN
    if (r_state == ST_ACC) r_b1 <= w_rd;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) r_state <= ST_ACC;
        ST_ACC: begin
`ifdef DMEM_MISALIGN_SPLIT_EN
          if (r_split) begin
            r_state <= ST_BEAT2;
          end else
`endif
          begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= r_err;
            r_rsp_rdata <= (r_err || r_we) ? '0 : extend(r_ctl, w_ld);
            r_state     <= ST_RESP;
          end
        end
`ifdef DMEM_MISALIGN_SPLIT_EN
        ST_BEAT2: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
          r_rsp_rdata <= r_we ? '0 : extend(r_ctl, w_ld);
          r_state     <= ST_RESP;
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed, table-driven bench for dmem_ctrl; expectations adapt to DMEM_MISALIGN_SPLIT_EN.
module tb_dmem_ctrl;
  import dmem_pkg::*;

`ifdef DMEM_MISALIGN_SPLIT_EN
  localparam logic SE = 1'b0;
  localparam int   SL = 3;
`else
  localparam logic SE = 1'b1;
  localparam int   SL = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_ctl;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  ctl;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    string       name;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DEPTH_WORDS(1024)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ctl   (req_ctl),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Presents one request and returns once rsp_valid is seen (or the bound expires).
  // lat counts the accept cycle as 1; the response is left pending.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] ctl, output int lat);
    int w;
    w = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_ctl = ctl; req_valid = 1'b1;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) chk("req_ready_timeout", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_ctl = CTL_W; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'b0, rsp_err}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    vecs.push_back('{1'b1, 32'h010, 32'hDEADBEEF, CTL_W,  32'h0,        1'b0, 2, "sw_10"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        CTL_W,  32'hDEADBEEF, 1'b0, 2, "lw_10"});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        CTL_B,  32'hFFFFFFDE, 1'b0, 2, "lb_13"});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        CTL_BU, 32'h000000DE, 1'b0, 2, "lbu_13"});
    vecs.push_back('{1'b0, 32'h012, 32'h0,        CTL_H,  32'hFFFFDEAD, 1'b0, 2, "lh_12"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        CTL_HU, 32'h0000BEEF, 1'b0, 2, "lhu_10"});
    vecs.push_back('{1'b1, 32'h011, 32'hAAAAAA55, CTL_BU, 32'h0,        1'b0, 2, "sb_11"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        CTL_W,  32'hDEAD55EF, 1'b0, 2, "lw_after_sb"});
    vecs.push_back('{1'b0, 32'h011, 32'h0,        CTL_B,  32'h00000055, 1'b0, 2, "lb_pos"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        CTL_H,  32'h000055EF, 1'b0, 2, "lh_pos"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        3'b011, 32'h0,        1'b1, 2, "ld_ctl011"});
    vecs.push_back('{1'b1, 32'h010, 32'h0,        3'b111, 32'h0,        1'b1, 2, "st_ctl111"});
    vecs.push_back('{1'b0, 32'h1000, 32'h0,       CTL_W,  32'h0,        1'b1, 2, "lw_oor"});
    vecs.push_back('{1'b1, 32'h1000, 32'h0,       CTL_W,  32'h0,        1'b1, 2, "sw_oor"});
    vecs.push_back('{1'b1, 32'h1003, 32'h0,       CTL_BU, 32'h0,        1'b1, 2, "sb_oor"});
    vecs.push_back('{1'b0, 32'h010, 32'h0,        CTL_W,  32'hDEAD55EF, 1'b0, 2, "lw_unchanged"});
    vecs.push_back('{1'b1, 32'hFFC, 32'h01020304, CTL_W,  32'h0,        1'b0, 2, "sw_top"});
    vecs.push_back('{1'b0, 32'hFFC, 32'h0,        CTL_W,  32'h01020304, 1'b0, 2, "lw_top"});
    vecs.push_back('{1'b0, 32'hFFF, 32'h0,        CTL_BU, 32'h00000001, 1'b0, 2, "lbu_lastbyte"});
    vecs.push_back('{1'b0, 32'hFFF, 32'h0,        CTL_HU, 32'h0,        1'b1, 2, "lhu_cross_top"});
    vecs.push_back('{1'b0, 32'hFFE, 32'h0,        CTL_W,  32'h0,        1'b1, 2, "lw_cross_top"});
    vecs.push_back('{1'b1, 32'h014, 32'hAAAAAAAA, CTL_W,  32'h0,        1'b0, 2, "sw_14"});
    vecs.push_back('{1'b1, 32'h018, 32'hBBBBBBBB, CTL_W,  32'h0,        1'b0, 2, "sw_18"});
    vecs.push_back('{1'b1, 32'h016, 32'h11223344, CTL_W,  32'h0,        SE,   SL, "sw_split_16"});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        CTL_W,  SE ? 32'hAAAAAAAA : 32'h3344AAAA, 1'b0, 2, "lw_14_after"});
    vecs.push_back('{1'b0, 32'h018, 32'h0,        CTL_W,  SE ? 32'hBBBBBBBB : 32'hBBBB1122, 1'b0, 2, "lw_18_after"});
    vecs.push_back('{1'b0, 32'h016, 32'h0,        CTL_W,  SE ? 32'h0 : 32'h11223344, SE, SL, "lw_split_16"});
    vecs.push_back('{1'b0, 32'h017, 32'h0,        CTL_H,  SE ? 32'h0 : 32'h00002233, SE, SL, "lh_split_17"});
    vecs.push_back('{1'b0, 32'h013, 32'h0,        CTL_HU, SE ? 32'h0 : 32'h0000AADE, SE, SL, "lhu_split_13"});
    vecs.push_back('{1'b0, 32'h011, 32'h0,        CTL_H,  SE ? 32'h0 : 32'hFFFFAD55, SE, SL, "lh_inword_11"});
    vecs.push_back('{1'b1, 32'h015, 32'h00007788, CTL_HU, 32'h0,        SE,   SL, "sh_inword_15"});
    vecs.push_back('{1'b0, 32'h014, 32'h0,        CTL_W,  SE ? 32'hAAAAAAAA : 32'h337788AA, 1'b0, 2, "lw_14_after_sh"});

    foreach (vecs[i]) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ctl, lat);
      chk({vecs[i].name, "_rdata"}, rsp_rdata, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, {31'b0, rsp_err}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      finish_rsp();
    end

    // Back-pressure: response must hold steady while rsp_ready stays low.
    issue(1'b0, 32'h010, 32'h0, CTL_W, lat);
    held = rsp_rdata;
    chk("hold_first_rdata", held, 32'hDEAD55EF);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("hold_rsp_rdata", rsp_rdata, 32'hDEAD55EF);
      chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
    end
    finish_rsp();
    chk("after_hs_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("after_hs_req_ready", {31'b0, req_ready}, 32'd1);

    // Reset while a response is pending.
    issue(1'b0, 32'hFFC, 32'h0, CTL_W, lat);
    chk("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("resp_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("resp_rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("resp_rst_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Memory contents survive reset.
    issue(1'b0, 32'hFFC, 32'h0, CTL_W, lat);
    chk("post_rst_lw_rdata", rsp_rdata, 32'h01020304);
    chk("post_rst_lw_lat", 32'(lat), 32'd2);
    finish_rsp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised, byte-addressable RV32 data memory with a valid/ready request port and a valid/ready response port.
- Storage is organised as 4 byte-lane banks of DEPTH_WORDS entries.
- Supports byte, half and word loads/stores with sign or zero extension, range/encoding error reporting, and optional two-beat splitting of misaligned accesses.
- Sits between the core's MEM stage and on-chip data storage.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2, ≥ 4.
- AW, $clog2(DEPTH_WORDS), word-index width (derived; not overridden).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- req_ctl  in  3  access control:
  - 000 lbu/sb
  - 001 lhu/sh
  - 010 lw/sw
  - 100 lb
  - 101 lh
  - others illegal
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  illegal ctl, out-of-range access, or (macro off) misaligned access.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State returns to IDLE; rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Bank contents are not reset.
  - Reset mid-split abandons beat 2; beat-1 bytes already written stay written.
- FSM states: IDLE, ACC, BEAT2, RESP.
  - req_ready = (state==IDLE).
  - Accept = req_valid && req_ready; latch we, addr, wdata, ctl.
- Error checks are evaluated at accept, before any write:
  - ctl ∈ {011,110,111} → error.
  - Any byte of the access ≥ DEPTH_WORDS*4 → error. This includes the second word of a split; there is no wrap-around.
  - Misaligned = half with addr[0]=1, or word with addr[1:0]≠0.
  - On error: no bank is written; go IDLE→ACC→RESP with rsp_err=1, rsp_rdata=0.
- Aligned access:
  - At the accept edge, banks read (or write with lane enables) word addr[AW+1:2].
  - Byte: lane addr[1:0]. Half: lanes addr[1]*2+{0,1}. Word: all lanes.
  - Store data is replicated into the addressed lanes.
  - ACC edge: register extended rdata and err; go RESP. rsp_valid is high 2 cycles after accept.
- Split access (macro on only):
  - Beat 1 at the accept edge covers word W, lanes offset..3.
  - Beat 2 in the ACC cycle covers word W+1, remaining low lanes.
  - BEAT2 edge: assemble data and extend; go RESP. rsp_valid is high 3 cycles after accept.
- Extension:
  - ctl[2]=1 sign-extends from bit 7 (byte) or bit 15 (half).
  - Otherwise zero-extend. Word passes through unchanged.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready.
  - On rsp_valid && rsp_ready → IDLE, rsp_valid=0.
  - New requests are not accepted in the same cycle as a response handshake.
- Stores always return one response (rdata 0) so that the core can track completion.

Optional Feature:
- DMEM_MISALIGN_SPLIT_EN:
  - Defined: misaligned, in-range accesses are split into two beats as described above.
  - Undefined: misaligned accesses take the error path (rsp_err=1, no write, 2-cycle latency), and the BEAT2 state is not present.

Decomposition:
- dmem_pkg holds:
  - ctl encodings: CTL_B=3'b100, CTL_H=3'b101, CTL_W=3'b010, CTL_BU=3'b000, CTL_HU=3'b001.
  - FSM state typedef.
  - Lane-count constant NLANES=4.
- Sub-module dmem_bank: one byte-lane synchronous RAM (DEPTH_WORDS×8), with write enable and registered read. It is instantiated 4 times.

Test Plan:
- sw 0xDEADBEEF @0x10, then lw @0x10 → rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after accept.
- lb @0x13 after that store → 0xFFFFFFDE; lbu @0x13 → 0x000000DE; lh @0x12 → 0xFFFFDEAD; lhu @0x10 → 0x0000BEEF.
- sb 0x55 @0x11, then lw @0x10 → 0xDEAD55EF; other lanes untouched.
- Illegal ctl 3'b011, and lw @ DEPTH_WORDS*4 → err 1, rdata 0, following read shows memory unchanged.
- sw 0x11223344 @0x16:
  - Macro on → lw @0x14 gives 0x3344xxxx in bits 31:16, lw @0x18 gives 0x00001122 in bits 15:0, rsp latency 3.
  - Macro off → err 1 and no write.
- Hold rsp_ready=0 for 5 cycles → rsp_valid/rdata stable, req_ready=0.
- Assert rst_n=0 during RESP → next cycle rsp_valid=0, req_ready=1.
